// File: rtl/cs_resolve_seq.sv
// Sequential carry-propagate resolver: turns a carry-save pair (c,s) into c+s,
// adding CHUNK bits per cycle with a registered carry between beats.
module cs_resolve_seq #(
  parameter int WIDTH = 93,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int NB = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW = NB * CHUNK;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_c;
  logic [PW-1:0]    r_s;
  logic [PW-1:0]    r_acc;
  logic             r_cy;
  logic [BW-1:0]    r_beat;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_carry;
  logic [CHUNK:0]   w_add;
  logic [PW+CHUNK:0] w_cat;
  logic [PW:0]      w_fin;
  logic             w_last;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_carry = r_out_carry;
  assign w_last    = (r_beat == LAST_BEAT);

  // Operands are zero-padded to NB*CHUNK bits, so after the last beat the bit at
  // position WIDTH of {carry, accumulator} is exactly the carry out of bit WIDTH-1.
  always_comb begin
    w_add = {1'b0, r_c[CHUNK-1:0]} + {1'b0, r_s[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_cy};
    w_cat = {w_add, r_acc};
    w_fin = w_cat[PW+CHUNK:CHUNK];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next = S_ADD;
        else          w_next = S_IDLE;
      end
      S_ADD: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_ADD;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
        else           w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Result shifts in from the top one chunk per beat; the port only updates on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c         <= '0;
      r_s         <= '0;
      r_acc       <= '0;
      r_cy        <= 1'b0;
      r_beat      <= '0;
      r_out_sum   <= '0;
      r_out_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_c    <= PW'(in_c);
            r_s    <= PW'(in_s);
            r_acc  <= '0;
            r_cy   <= 1'b0;
            r_beat <= '0;
          end
        end
        S_ADD: begin
          r_c    <= r_c >> CHUNK;
          r_s    <= r_s >> CHUNK;
          r_acc  <= w_fin[PW-1:0];
          r_cy   <= w_fin[PW];
          r_beat <= r_beat + BW'(1);
          if (w_last) begin
            r_out_sum   <= w_fin[WIDTH-1:0];
            r_out_carry <= w_fin[WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_resolve_seq.sv
// Bench for cs_resolve_seq: three instances (CHUNK = 32, 93, 1) checked every cycle
// against a timeline model of c+s, plus directed literal cases.
module tb_cs_resolve_seq;

  localparam int W = 93;

  function automatic int ch_of(input int g);
    case (g)
      0:       return 32;
      1:       return 93;
      default: return 1;
    endcase
  endfunction

  function automatic int nb(input int g);
    return (W + ch_of(g) - 1) / ch_of(g);
  endfunction

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [2:0]   out_carry;
  logic [W-1:0] in_c    [3];
  logic [W-1:0] in_s    [3];
  logic [W-1:0] out_sum [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cs_resolve_seq #(.WIDTH(W), .CHUNK(ch_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_c      (in_c[g]),
      .in_s      (in_s[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_sum   (out_sum[g]),
      .out_carry (out_carry[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int i, input logic [W:0] act, input logic [W:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input int i, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0b, expected %0b", nm, i, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int i, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, i, act, exp);
    end
  endtask

  // Model: an accepted pair becomes visible exactly nb() edges later and stays until taken.
  logic         m_busy  [3];
  int           m_cnt   [3];
  logic [W:0]   m_res   [3];
  logic [W:0]   m_shown [3];
  int           m_rcv   [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i]  <= 1'b0;
        m_cnt[i]   <= 0;
        m_shown[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_busy[i]) begin
          if (in_valid[i]) begin
            m_busy[i] <= 1'b1;
            m_cnt[i]  <= 0;
            m_res[i]  <= {1'b0, in_c[i]} + {1'b0, in_s[i]};
          end
        end else if (m_cnt[i] < nb(i)) begin
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == nb(i)) m_shown[i] <= m_res[i];
        end else if (out_ready[i]) begin
          m_busy[i] <= 1'b0;
          m_rcv[i]  <= m_rcv[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chkb("in_ready", i, in_ready[i], !m_busy[i]);
        chkb("out_valid", i, out_valid[i], m_busy[i] && (m_cnt[i] == nb(i)));
        chk("result", i, {out_carry[i], out_sum[i]}, m_shown[i]);
      end
    end
  end

  int last_lat [3];

  task automatic run_pair(input logic [W-1:0] c, input logic [W-1:0] s,
                          input logic [W:0] exp, input int hold);
    int   lat [3];
    logic [2:0] seen;
    for (int i = 0; i < 3; i++) begin
      in_c[i] = c;
      in_s[i] = s;
      lat[i]  = -1;
    end
    in_valid  = 3'b111;
    out_ready = 3'b000;
    @(posedge clk); #1;
    in_valid = 3'b000;
    seen = 3'b000;
    for (int cyc = 0; cyc <= 200; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && out_valid[i]) begin
          seen[i] = 1'b1;
          lat[i]  = cyc;
        end
      end
      if (seen == 3'b111) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      chki("latency", i, lat[i], nb(i));
      chk("sum", i, {out_carry[i], out_sum[i]}, exp);
      last_lat[i] = lat[i];
    end
    repeat (hold) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chkb("bp_valid", i, out_valid[i], 1'b1);
        chkb("bp_ready", i, in_ready[i], 1'b0);
        chk("bp_sum", i, {out_carry[i], out_sum[i]}, exp);
      end
    end
    out_ready = 3'b111;
    @(posedge clk); #1;
    out_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chkb("rel_valid", i, out_valid[i], 1'b0);
      chkb("rel_ready", i, in_ready[i], 1'b1);
    end
  endtask

  task automatic gen_pair(input int i);
    logic [W-1:0] ones;
    logic [W-1:0] r;
    ones = '1;
    r = W'({$urandom, $urandom, $urandom});
    case ($urandom_range(7, 0))
      0: begin in_c[i] = ones; in_s[i] = W'($urandom_range(3, 0)); end
      1: begin in_c[i] = r;    in_s[i] = ~r; end
      2: begin in_c[i] = r;    in_s[i] = (~r) + W'(1); end
      default: begin
        in_c[i] = r;
        in_s[i] = W'({$urandom, $urandom, $urandom});
      end
    endcase
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] one;
    int   target [3];
    int   sent   [3];
    int   base   [3];
    logic [2:0] rdy_prev;
    logic acc;
    bit   all_done;

    ones = '1;
    one  = W'(1);
    target = '{1500, 1500, 250};
    rst_n = 1'b0;
    in_valid = 3'b000;
    out_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      in_c[i] = '0;
      in_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chkb("rst_ready", i, in_ready[i], 1'b1);
      chkb("rst_valid", i, out_valid[i], 1'b0);
      chk("rst_sum", i, {out_carry[i], out_sum[i]}, 94'd0);
    end

    run_pair(93'd0, 93'd5, 94'd5, 0);
    chki("t1_lat", 0, last_lat[0], 3);
    chki("t1_lat", 1, last_lat[1], 1);
    chki("t1_lat", 2, last_lat[2], 93);
    run_pair(ones, 93'd1, {1'b1, 93'd0}, 0);
    run_pair(one << 31, one << 31, 94'h1_0000_0000, 0);
    run_pair(one << 63, one << 63, 94'h1_0000_0000_0000_0000, 5);

    // Reset during the second add beat; the previous non-zero result must vanish.
    for (int i = 0; i < 3; i++) begin
      in_c[i] = ones;
      in_s[i] = ones;
    end
    in_valid = 3'b111;
    @(posedge clk); #1;
    in_valid = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chkb("mid_rst_valid", i, out_valid[i], 1'b0);
      chkb("mid_rst_ready", i, in_ready[i], 1'b1);
      chk("mid_rst_sum", i, {out_carry[i], out_sum[i]}, 94'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_pair(93'd123456789, 93'd987654321, 94'd1111111110, 0);

    for (int i = 0; i < 3; i++) begin
      base[i] = m_rcv[i];
      sent[i] = 0;
    end
    rdy_prev = 3'b000;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        acc = in_valid[i] && rdy_prev[i];
        if (acc) sent[i]++;
        if (acc || !in_valid[i]) begin
          if (sent[i] < target[i] && $urandom_range(3, 0) != 0) begin
            in_valid[i] = 1'b1;
            gen_pair(i);
          end else begin
            in_valid[i] = 1'b0;
          end
        end
        out_ready[i] = ($urandom_range(2, 0) != 0);
      end
      rdy_prev = in_ready;
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (sent[i] != target[i] || (m_rcv[i] - base[i]) != target[i]) all_done = 1'b0;
      end
      if (all_done) break;
      @(posedge clk); #1;
    end
    in_valid = 3'b000;
    out_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chki("sent", i, sent[i], target[i]);
      chki("received", i, m_rcv[i] - base[i], target[i]);
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
